// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues one word request at a time
//   to instruction memory, and registers each returned word with its address
//   into the IF/ID output. A one-entry skid buffer absorbs the response that
//   arrives while decode stalls. Redirects discard responses already in flight.
//
// Handshake: imem_req/imem_addr form a request that stays stable until
//   imem_ack is seen high on a rising edge; a response is consumed only when
//   imem_req is high, so a stray ack with imem_req low is ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr/req     request address (word aligned) and valid
//   imem_ack/data/err response valid, instruction word, bus error
//   stall             decode cannot accept; outputs hold while valid
//   redirect/_pc      branch/jump/flush and its target
//   pc/instruction    IF/ID output; instruction is NOP when not valid
//   if_valid/if_fault output holds a real fetch / that fetch faulted
//   dbg_state         FSM state (0 FETCH, 1 FULL, 2 KILL)
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        imem_err,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        if_valid,
    output logic        if_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_KILL  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_WORD = {RESET_ADDR[31:2], 2'b00};

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        skid_fault_q, skid_fault_d;

    logic        ack_v;
    logic        load;
    logic [31:0] target;
    logic [31:0] resp_instr;

    // An ack only counts against a live request.
    assign ack_v      = imem_ack && req_q;
    assign load       = !stall || !valid_q;
    assign target     = {redirect_pc[31:2], 2'b00};
    assign resp_instr = imem_err ? NOP : imem_data;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            req_q        <= 1'b0;
            addr_q       <= RESET_WORD;
            pending_q    <= RESET_WORD;
            pc_q         <= RESET_WORD;
            instr_q      <= NOP;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            skid_pc_q    <= RESET_WORD;
            skid_instr_q <= NOP;
            skid_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pending_q    <= pending_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_fault_q <= skid_fault_d;
        end
    end

    // Next-state logic. Redirect wins over everything; a request that is
    // still outstanding must be waited out in KILL so its response is dropped.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = (!req_q || ack_v) ? S_FETCH : S_KILL;
        end else begin
            case (state_q)
                S_FETCH: if (ack_v && !load) state_d = S_FULL;
                S_FULL:  if (!stall)         state_d = S_FETCH;
                S_KILL:  if (ack_v)          state_d = S_FETCH;
                default:                     state_d = S_FETCH;
            endcase
        end
    end

    // Datapath / output register next values.
    always_comb begin
        // Request is registered so it is low for the first cycle after reset
        // and resumes one cycle after the skid drains.
        req_d        = (state_d != S_FULL);
        addr_d       = addr_q;
        pending_d    = pending_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_fault_d = skid_fault_q;

        if (redirect) begin
            valid_d = 1'b0;
            instr_d = NOP;
            fault_d = 1'b0;
            if (!req_q || ack_v) begin
                addr_d = target;
            end else begin
                pending_d = target;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_v) begin
                        addr_d = addr_q + 32'd4;
                        if (load) begin
                            pc_d    = addr_q;
                            instr_d = resp_instr;
                            valid_d = 1'b1;
                            fault_d = imem_err;
                        end else begin
                            skid_pc_d    = addr_q;
                            skid_instr_d = resp_instr;
                            skid_fault_d = imem_err;
                        end
                    end else if (load) begin
                        valid_d = 1'b0;
                        instr_d = NOP;
                        fault_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        pc_d    = skid_pc_q;
                        instr_d = skid_instr_q;
                        valid_d = 1'b1;
                        fault_d = skid_fault_q;
                    end
                end
                S_KILL: begin
                    // The stale response is dropped; fetch the pending target.
                    if (ack_v) addr_d = pending_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign if_valid    = valid_q;
    assign if_fault    = fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] DMASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        imem_err;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        if_valid;
  logic        if_fault;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  // memory model controls
  logic        mem_en;
  int          mem_lat;
  int          mem_cnt;
  logic [31:0] err_addr;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .imem_err(imem_err),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .instruction(instruction),
    .if_valid(if_valid), .if_fault(if_fault), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Memory: acks a live request mem_lat cycles after it starts, data = addr ^ DMASK.
  always @(negedge clk) begin
    if (mem_en) begin
      if (!imem_req) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (mem_cnt == mem_lat) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ DMASK;
        imem_err  = (imem_addr == err_addr);
        mem_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        mem_cnt  = mem_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given memory latency; returns just after release (cycle 0).
  task automatic do_reset(input int lat);
    mem_lat  = lat;
    stall    = 1'b0;
    redirect = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected 0", pc); end
    tests_run++; if (instruction !== NOP_W) begin tests_failed++; $display("FAIL reset_instr: got %h expected %h", instruction, NOP_W); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    tests_run++; if (if_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b expected 0", if_fault); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    tick();
    tests_run++; if (imem_req !== 1'b1 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_cycle1: got req=%b valid=%b expected req=1 valid=0", imem_req, if_valid); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ea;
      ea = 32'(k * 4);
      tick();
      tests_run++;
      if (pc !== ea || instruction !== (ea ^ DMASK) || if_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_word%0d: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", k, pc, instruction, if_valid, ea, ea ^ DMASK);
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset(0);
    repeat (4) tick();
    tests_run++; if (pc !== 32'h8 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_pre: got pc=%h valid=%b expected pc=8 valid=1", pc, if_valid); end
    stall = 1'b1;
    tick();
    tests_run++; if (pc !== 32'h8 || imem_req !== 1'b0 || dbg_state !== 2'd1) begin tests_failed++; $display("FAIL stall_capture: got pc=%h req=%b state=%0d expected pc=8 req=0 state=1", pc, imem_req, dbg_state); end
    tick();
    tests_run++; if (pc !== 32'h8 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_hold2: got pc=%h req=%b expected pc=8 req=0", pc, imem_req); end
    tick();
    tests_run++; if (pc !== 32'h8 || instruction !== (32'h8 ^ DMASK) || if_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold3: got pc=%h instr=%h valid=%b expected pc=8", pc, instruction, if_valid); end
    stall = 1'b0;
    tick();
    tests_run++; if (pc !== 32'hC || instruction !== (32'hC ^ DMASK) || imem_req !== 1'b1) begin tests_failed++; $display("FAIL skid_drain: got pc=%h instr=%h req=%b expected pc=c req=1", pc, instruction, imem_req); end
    tick();
    tests_run++; if (pc !== 32'h10 || instruction !== (32'h10 ^ DMASK) || if_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_resume: got pc=%h instr=%h valid=%b expected pc=10", pc, instruction, if_valid); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3);
    repeat (10) tick();
    tests_run++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL redir_pre: got addr=%h req=%b expected addr=8 req=1", imem_addr, imem_req); end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tests_run++; if (imem_addr !== 32'h8 || dbg_state !== 2'd2 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_kill: got addr=%h state=%0d valid=%b expected addr=8 state=2 valid=0", imem_addr, dbg_state, if_valid); end
    tick();
    tests_run++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_hold: got addr=%h valid=%b expected addr=8 valid=0", imem_addr, if_valid); end
    tick();
    tests_run++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_target: got addr=%h valid=%b expected addr=100 valid=0", imem_addr, if_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_gap%0d: got valid=%b pc=%h expected valid=0", k, if_valid, pc); end
    end
    tick();
    tests_run++; if (pc !== 32'h100 || instruction !== (32'h100 ^ DMASK) || if_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_first: got pc=%h instr=%h valid=%b expected pc=100 valid=1", pc, instruction, if_valid); end
  endtask

  task automatic test_double_redirect();
    do_reset(3);
    repeat (10) tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    tests_run++; if (imem_addr !== 32'h8 || dbg_state !== 2'd2) begin tests_failed++; $display("FAIL dbl_first: got addr=%h state=%0d expected addr=8 state=2", imem_addr, dbg_state); end
    redirect_pc = 32'h303;
    tick();
    redirect = 1'b0;
    tests_run++; if (imem_addr !== 32'h8 || dbg_state !== 2'd2) begin tests_failed++; $display("FAIL dbl_second: got addr=%h state=%0d expected addr=8 state=2", imem_addr, dbg_state); end
    tick();
    tests_run++; if (imem_addr !== 32'h300) begin tests_failed++; $display("FAIL dbl_target: got addr=%h expected 300", imem_addr); end
    repeat (3) tick();
    tick();
    tests_run++; if (pc !== 32'h300 || instruction !== (32'h300 ^ DMASK) || if_valid !== 1'b1) begin tests_failed++; $display("FAIL dbl_fetch: got pc=%h instr=%h valid=%b expected pc=300 valid=1", pc, instruction, if_valid); end
  endtask

  task automatic test_bus_error();
    err_addr = 32'h10;
    do_reset(0);
    repeat (6) tick();
    tests_run++; if (pc !== 32'h10 || if_fault !== 1'b1 || instruction !== NOP_W || if_valid !== 1'b1) begin tests_failed++; $display("FAIL err_fault: got pc=%h fault=%b instr=%h valid=%b expected pc=10 fault=1 instr=13 valid=1", pc, if_fault, instruction, if_valid); end
    tick();
    tests_run++; if (pc !== 32'h14 || if_fault !== 1'b0 || instruction !== (32'h14 ^ DMASK)) begin tests_failed++; $display("FAIL err_next: got pc=%h fault=%b instr=%h expected pc=14 fault=0", pc, if_fault, instruction); end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_wrap();
    do_reset(0);
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tests_run++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_redir: got addr=%h valid=%b expected addr=fffffffc valid=0", imem_addr, if_valid); end
    tick();
    tests_run++; if (pc !== 32'hFFFF_FFFC || if_valid !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_top: got pc=%h valid=%b addr=%h expected pc=fffffffc valid=1 addr=0", pc, if_valid, imem_addr); end
    tick();
    tests_run++; if (pc !== 32'h0 || instruction !== DMASK) begin tests_failed++; $display("FAIL wrap_zero: got pc=%h instr=%h expected pc=0 instr=a5a50000", pc, instruction); end
  endtask

  task automatic test_async_reset_mid_stall();
    do_reset(0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    tests_run++; if (dbg_state !== 2'd1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL areset_pre: got state=%0d req=%b expected state=1 req=0", dbg_state, imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || instruction !== NOP_W || if_valid !== 1'b0 || if_fault !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_now: got req=%b addr=%h pc=%h instr=%h valid=%b fault=%b state=%0d expected reset values", imem_req, imem_addr, pc, instruction, if_valid, if_fault, dbg_state);
    end
    mem_en    = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    stall     = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (if_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL areset_stale: got valid=%b addr=%h req=%b expected valid=0 addr=0 req=1", if_valid, imem_addr, imem_req); end
    imem_ack = 1'b0;
    mem_cnt  = 0;
    mem_en   = 1'b1;
    tick();
    tests_run++; if (pc !== 32'h0 || instruction !== DMASK || if_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_first: got pc=%h instr=%h valid=%b expected pc=0 instr=a5a50000 valid=1", pc, instruction, if_valid); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_data    = 32'h0;
    imem_err     = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    mem_en       = 1'b1;
    mem_lat      = 0;
    mem_cnt      = 0;
    err_addr     = 32'hFFFF_FFFF;

    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_inflight();
    test_double_redirect();
    test_bus_error();
    test_wrap();
    test_async_reset_mid_stall();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Titan RV32I pipeline. Holds the program counter and issues one-outstanding word requests to instruction memory. Registers each returned word with its PC into the IF/ID output, which feeds the `pc`/`instruction` inputs of the decode unit. Handles decode back-pressure through a one-entry skid buffer, and branch/jump/flush redirects by discarding in-flight responses.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low (one clock domain only).
- `imem_addr`  out  32  word address of the current request; bits [1:0] always 0.
- `imem_req`  out  1  request valid.
- `imem_ack`  in  1  response valid; may be asserted in the same cycle as `imem_req`.
- `imem_data`  in  32  instruction word, valid with `imem_ack`.
- `imem_err`  in  1  bus error, valid with `imem_ack`.
- `stall`  in  1  decode cannot accept; hold outputs.
- `redirect`  in  1  branch/jump taken or pipeline flush.
- `redirect_pc`  in  32  target; bits [1:0] forced to 0 internally.
- `pc`  out  32  PC of `instruction`.
- `instruction`  out  32  fetched word, or `NOP` when not valid.
- `if_valid`  out  1  `pc`/`instruction` hold a real fetched instruction.
- `if_fault`  out  1  the fetch at `pc` returned `imem_err`.

## Operation
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_ADDR`, `pc`=`RESET_ADDR`, `instruction`=`NOP`, `if_valid`=0, `if_fault`=0, skid empty, state FETCH.
- **States:** FETCH, FULL and KILL.
- **FETCH:**
  - `imem_req`=1.
  - `imem_addr` and `imem_req` are stable until `imem_ack`.
  - On ack: `imem_addr` becomes `imem_addr`+4 at that edge (32-bit wrap, 0xFFFF_FFFC → 0).
- **Output load condition:** `!stall || !if_valid`.
  - When the load condition holds, an acked word goes to the outputs: `pc`=request address, `instruction`=`imem_data` (or `NOP` if `imem_err`), `if_valid`=1, `if_fault`=`imem_err`.
  - When it does not hold, the ack is captured in the skid buffer and the state goes to FULL.
  - When the load condition holds and there is no ack, `if_valid` becomes 0 and `instruction` becomes `NOP`.
- **FULL:**
  - `imem_req`=0.
  - When `stall`=0: the skid entry moves to the outputs, the skid is emptied, and the state goes to FETCH. The request resumes the following cycle.
- **Redirect (highest priority, any state):**
  - `if_valid` becomes 0, `instruction` becomes `NOP`, `if_fault` becomes 0, the skid is emptied.
  - Any ack in the redirect cycle is dropped.
  - If no request is outstanding, or the request is acked in the redirect cycle: `imem_addr` becomes the target and the state goes to FETCH.
  - Otherwise: the state goes to KILL and the target is latched as pending.
  - `stall` is ignored during the redirect cycle.
- **KILL:**
  - `imem_req` and `imem_addr` are held (handshake stability).
  - The ack is dropped.
  - On ack: `imem_addr` becomes the pending target and the state goes to FETCH.
  - A new redirect in KILL overwrites the pending target.
- Only one request is ever outstanding. Responses are never reordered.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle. `pc` sequence after reset is `RESET_ADDR`, +4, +8, … with the first `if_valid`=1 at cycle 2 after `rst_n` rises. In cycle 1, `imem_req`=1 and the ack arrives; the output register loads at that edge.
- N-cycle memory latency gives one instruction per N+1 cycles at most; `if_valid`=0 between instructions.
- Redirect latency:
  - Target appears on `imem_addr` the cycle after `redirect` if no request is pending; otherwise the cycle after the pending ack.
  - First target instruction is valid at least 2 cycles after `redirect`.
- Stall: outputs change on no edge where `stall`=1 and `if_valid`=1, except on redirect.
- Skid drain: `stall` falls at edge E; the skid word is on the outputs after E+1. The next request is issued in cycle E+1.
- Reset asserted mid-request: all state returns to reset values immediately. A later stale ack while `imem_req`=0 is ignored.

## Test plan
- **Reset/stream:**
  - Stimulus: `RESET_ADDR`=0, memory acks every request in the same cycle with data=addr ^ 32'hA5A5_0000.
  - Required: `pc`=0,4,8,12 on consecutive cycles, `instruction` matches, `if_valid`=1 continuously.
- **Stall/skid:**
  - Stimulus: raise `stall` for 3 cycles while streaming.
  - Required: `pc` is held, `imem_req` drops after one captured word, no instruction is lost or duplicated after release (sequence continues +4).
- **Redirect with in-flight request:**
  - Stimulus: 3-cycle memory; `redirect`=1 with `redirect_pc`=0x100 one cycle after the request at 0x8.
  - Required: the 0x8 data never appears with `if_valid`=1, the next `imem_addr` is 0x100, `pc`=0x100 valid next.
- **Double redirect in KILL:**
  - Stimulus: targets 0x200 then 0x300 before the pending ack.
  - Required: only 0x300 is fetched.
- **Bus error:**
  - Stimulus: `imem_err`=1 on the fetch at 0x10.
  - Required: `pc`=0x10, `if_fault`=1, `instruction`=32'h0000_0013; the next fetch at 0x14 has `if_fault`=0.
- **Async reset mid-stall:**
  - Stimulus: pull `rst_n` low while FULL.
  - Required: outputs equal reset values in the same cycle; the first fetch after release is `RESET_ADDR`.
